// File: rtl/i2c_led_seq_if.sv
// Byte stream from the I2C slave into the LED sequencer, plus frame-buffer and refresh outputs.
// master drives the received bytes and driver status; slave is the sequencer.
interface i2c_led_seq_if #(
    parameter int IDX_W = 3
);
    logic [7:0]       data;
    logic             data_valid;
    logic             address_valid;
    logic             drv_busy_i;
    logic             wr_en_o;
    logic [IDX_W-1:0] wr_addr_o;
    logic [23:0]      wr_data_o;
    logic             refresh_o;
    logic             idx_err_o;

    modport master (
        output data, data_valid, address_valid, drv_busy_i,
        input  wr_en_o, wr_addr_o, wr_data_o, refresh_o, idx_err_o
    );

    modport slave (
        input  data, data_valid, address_valid, drv_busy_i,
        output wr_en_o, wr_addr_o, wr_data_o, refresh_o, idx_err_o
    );
endinterface

// File: rtl/i2c_led_seq.sv
// Turns I2C write bytes (start index, then RGB triplets) into frame-buffer writes and a refresh request.
// Latency: write strobe one clock after the third colour byte; refresh one clock after idle with driver free.
// Backpressure: none on the byte stream; refresh is held pending while drv_busy_i is high.
module i2c_led_seq #(
    parameter int NUM_LEDS = 8,
    parameter int IDX_W    = 3
) (
    input  logic          clk,
    input  logic          reset,
    i2c_led_seq_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, INDEX, C0, C1, C2, DISCARD} state_t;

    state_t           state;
    logic             av_q;
    logic [IDX_W-1:0] idx;
    logic [7:0]       byte0;
    logic [7:0]       byte1;
    logic             wr_seen;
    logic             refresh_pending;

    logic             av_rise;
    logic             in_range;
    logic [IDX_W-1:0] idx_next;

    assign av_rise  = bus.address_valid & ~av_q;
    assign in_range = {1'b0, bus.data} < 9'(NUM_LEDS);
    assign idx_next = (idx == IDX_W'(NUM_LEDS - 1)) ? '0 : idx + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            av_q            <= 1'b0;
            idx             <= '0;
            byte0           <= 8'h00;
            byte1           <= 8'h00;
            wr_seen         <= 1'b0;
            refresh_pending <= 1'b0;
            bus.wr_en_o     <= 1'b0;
            bus.wr_addr_o   <= '0;
            bus.wr_data_o   <= 24'h000000;
            bus.refresh_o   <= 1'b0;
            bus.idx_err_o   <= 1'b0;
        end else begin
            av_q          <= bus.address_valid;
            bus.wr_en_o   <= 1'b0;
            bus.refresh_o <= 1'b0;

            if (state == IDLE && refresh_pending && !bus.drv_busy_i) begin
                bus.refresh_o   <= 1'b1;
                refresh_pending <= 1'b0;
            end

            // Losing the address ends the transaction and drops any partial colour.
            if (state != IDLE && !bus.address_valid) begin
                state <= IDLE;
                if (wr_seen) begin
                    refresh_pending <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (av_rise) begin
                            state         <= INDEX;
                            bus.idx_err_o <= 1'b0;
                            wr_seen       <= 1'b0;
                        end
                    end
                    INDEX: begin
                        if (bus.data_valid) begin
                            if (in_range) begin
                                idx   <= bus.data[IDX_W-1:0];
                                state <= C0;
                            end else begin
                                bus.idx_err_o <= 1'b1;
                                state         <= DISCARD;
                            end
                        end
                    end
                    C0: begin
                        if (bus.data_valid) begin
                            byte0 <= bus.data;
                            state <= C1;
                        end
                    end
                    C1: begin
                        if (bus.data_valid) begin
                            byte1 <= bus.data;
                            state <= C2;
                        end
                    end
                    C2: begin
                        if (bus.data_valid) begin
                            bus.wr_en_o   <= 1'b1;
                            bus.wr_addr_o <= idx;
                            bus.wr_data_o <= {byte0, byte1, bus.data};
                            idx           <= idx_next;
                            wr_seen       <= 1'b1;
                            state         <= C0;
                        end
                    end
                    DISCARD: begin
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_led_seq.sv
// Randomized and directed stimulus for i2c_led_seq, checked against a transaction-level model.
module tb_i2c_led_seq;

    localparam int N  = 8;
    localparam int IW = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    i2c_led_seq_if #(.IDX_W(IW)) bus ();

    i2c_led_seq #(.NUM_LEDS(N), .IDX_W(IW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] act_q[$];
    logic [31:0] exp_q[$];
    logic [7:0]  stim_q[$];
    int          ref_cnt = 0;
    int          exp_ref = 0;
    bit          pend    = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.wr_en_o) act_q.push_back(32'({bus.wr_addr_o, bus.wr_data_o}));
        if (bus.refresh_o) ref_cnt++;
    end

    task automatic compare_writes();
        check("wr_count", act_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
            check("wr_entry", act_q[i], exp_q[i]);
        act_q.delete();
        exp_q.delete();
    endtask

    // Caller is positioned at a falling edge; returns at a falling edge.
    task automatic send_byte(input logic [7:0] b, input bit exp_wr, input int gap);
        bus.data       = b;
        bus.data_valid = 1'b1;
        @(negedge clk);
        bus.data_valid = 1'b0;
        check("wr_strobe", 32'(bus.wr_en_o), 32'(exp_wr));
        repeat (gap) @(negedge clk);
    endtask

    // stim_q[0] is the start index, the rest are colour bytes.
    task automatic run_txn(input bit busy_v, input bit rand_gap);
        int idx;
        bit valid;
        int nw;
        idx   = int'(stim_q[0]);
        valid = idx < N;
        nw    = 0;
        bus.drv_busy_i = busy_v;
        if (!busy_v && pend) begin exp_ref++; pend = 1'b0; end
        bus.address_valid = 1'b1;
        @(negedge clk);
        send_byte(stim_q[0], 1'b0, rand_gap ? int'($urandom_range(0, 2)) : 0);
        for (int p = 1; p < stim_q.size(); p++) begin
            bit c;
            c = valid && ((p - 1) % 3 == 2);
            if (c) begin
                exp_q.push_back(32'({IW'((idx + nw) % N), stim_q[p-2], stim_q[p-1], stim_q[p]}));
                nw++;
            end
            send_byte(stim_q[p], c, rand_gap ? int'($urandom_range(0, 2)) : 0);
        end
        bus.address_valid = 1'b0;
        repeat (3) @(negedge clk);
        if (nw > 0) pend = 1'b1;
        if (!busy_v && pend) begin exp_ref++; pend = 1'b0; end
        check("idx_err", 32'(bus.idx_err_o), 32'(!valid));
        compare_writes();
        check("refresh_cnt", ref_cnt, exp_ref);
    endtask

    initial begin
        reset             = 1'b1;
        bus.data          = 8'h00;
        bus.data_valid    = 1'b0;
        bus.address_valid = 1'b0;
        bus.drv_busy_i    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_wr_en",   32'(bus.wr_en_o),   0);
        check("rst_refresh", 32'(bus.refresh_o), 0);
        check("rst_idx_err", 32'(bus.idx_err_o), 0);
        check("rst_wr_addr", 32'(bus.wr_addr_o), 0);
        check("rst_wr_data", 32'(bus.wr_data_o), 0);
        reset = 1'b0;
        @(negedge clk);

        stim_q = '{8'h00, 8'hAB, 8'h36, 8'h84, 8'hD0, 8'h25, 8'h5A, 8'h00, 8'h77, 8'h0D};
        run_txn(1'b0, 1'b0);

        stim_q = '{8'h07, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
        run_txn(1'b0, 1'b0);

        stim_q = '{8'h08, 8'h01, 8'h02, 8'h03};
        run_txn(1'b0, 1'b0);

        stim_q = '{8'h02, 8'hAA, 8'hBB};
        run_txn(1'b0, 1'b0);
        stim_q = '{8'h05, 8'hC1, 8'hC2, 8'hC3};
        run_txn(1'b0, 1'b1);

        // Two transactions while the driver is busy coalesce into one refresh.
        stim_q = '{8'h01, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26};
        run_txn(1'b1, 1'b1);
        stim_q = '{8'h06, 8'h31, 8'h32, 8'h33};
        run_txn(1'b1, 1'b1);
        bus.drv_busy_i = 1'b0;
        @(negedge clk);
        check("refresh_on_release", 32'(bus.refresh_o), 1);
        exp_ref++;
        pend = 1'b0;
        repeat (4) @(negedge clk);
        check("refresh_coalesced", ref_cnt, exp_ref);

        // Address drop coincident with the C2 byte wins over the byte.
        bus.address_valid = 1'b1;
        @(negedge clk);
        send_byte(8'h04, 1'b0, 0);
        send_byte(8'h10, 1'b0, 0);
        send_byte(8'h20, 1'b0, 0);
        bus.data          = 8'h30;
        bus.data_valid    = 1'b1;
        bus.address_valid = 1'b0;
        @(negedge clk);
        bus.data_valid = 1'b0;
        check("fall_beats_byte", 32'(bus.wr_en_o), 0);
        repeat (3) @(negedge clk);
        compare_writes();
        check("fall_no_refresh", ref_cnt, exp_ref);

        // Reset during C2 with a refresh pending behind a busy driver.
        bus.drv_busy_i    = 1'b1;
        bus.address_valid = 1'b1;
        @(negedge clk);
        send_byte(8'h03, 1'b0, 0);
        send_byte(8'h01, 1'b0, 0);
        send_byte(8'h02, 1'b0, 0);
        exp_q.push_back(32'h03010203);
        send_byte(8'h03, 1'b1, 0);
        send_byte(8'h04, 1'b0, 0);
        send_byte(8'h05, 1'b0, 0);
        bus.data       = 8'h06;
        bus.data_valid = 1'b1;
        reset          = 1'b1;
        @(negedge clk);
        bus.data_valid    = 1'b0;
        bus.address_valid = 1'b0;
        check("mid_rst_wr_en",   32'(bus.wr_en_o),   0);
        check("mid_rst_refresh", 32'(bus.refresh_o), 0);
        check("mid_rst_idx_err", 32'(bus.idx_err_o), 0);
        check("mid_rst_wr_addr", 32'(bus.wr_addr_o), 0);
        check("mid_rst_wr_data", 32'(bus.wr_data_o), 0);
        reset          = 1'b0;
        pend           = 1'b0;
        bus.drv_busy_i = 1'b0;
        repeat (10) @(negedge clk);
        compare_writes();
        check("rst_no_refresh", ref_cnt, exp_ref);

        for (int t = 0; t < 25; t++) begin
            int ncol;
            stim_q.delete();
            stim_q.push_back(8'($urandom_range(0, 10)));
            ncol = int'($urandom_range(0, 12));
            for (int k = 0; k < ncol; k++) stim_q.push_back(8'($urandom));
            run_txn(1'($urandom_range(0, 1)), 1'b1);
        end
        bus.drv_busy_i = 1'b0;
        if (pend) begin exp_ref++; pend = 1'b0; end
        repeat (4) @(negedge clk);
        check("final_refresh_cnt", ref_cnt, exp_ref);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_led_seq.md
I2C_LED_SEQ -- requirements
Module: i2c_led_seq

Interface
REQ-001 Parameter NUM_LEDS, default 8: number of LED entries in the frame buffer; legal range 2..256.
REQ-002 Parameter IDX_W, default 3: width of the LED index; SHALL equal ceil(log2(NUM_LEDS)).
REQ-003 clk  input  1  single system clock; all logic is on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 data  input  8  byte received by the I2C slave; valid only while data_valid is high.
REQ-006 data_valid  input  1  one-cycle strobe per received write byte.
REQ-007 address_valid  input  1  level, high from address match until STOP or repeated START.
REQ-008 drv_busy_i  input  1  LED driver is shifting out a frame.
REQ-009 wr_en_o  output  1  one-cycle frame-buffer write strobe.
REQ-010 wr_addr_o  output  IDX_W  frame-buffer index for the write.
REQ-011 wr_data_o  output  24  colour word {byte0, byte1, byte2}.
REQ-012 refresh_o  output  1  one-cycle request telling the LED driver to send the frame.
REQ-013 idx_err_o  output  1  sticky flag: the start index was out of range.

Function
REQ-014 FSM states SHALL be IDLE, INDEX, C0, C1, C2, DISCARD.
REQ-015 address_valid rising edge (registered previous value was 0, current is 1) SHALL move IDLE->INDEX, clear idx_err_o and clear the per-transaction write count.
REQ-016 In INDEX, a data_valid byte below NUM_LEDS SHALL load the index register and go to C0; a byte of NUM_LEDS or more SHALL set idx_err_o and go to DISCARD.
REQ-017 In C0 and C1, data_valid SHALL latch the byte into colour byte 0 or 1 and advance to C1 or C2 respectively.
REQ-018 In C2, data_valid SHALL latch byte 2 and return to C0.
REQ-019 On the clock after the C2 byte, wr_en_o SHALL be high for exactly one cycle, with wr_addr_o set to the current index and wr_data_o = {byte0, byte1, byte2}.
REQ-020 In the same cycle as that write, the index SHALL increment and wrap from NUM_LEDS-1 to 0.
REQ-021 In DISCARD, all bytes SHALL be ignored and no write SHALL occur.
REQ-022 address_valid low in any non-IDLE state SHALL force IDLE on the next clock; any partial colour bytes SHALL be discarded.
REQ-023 When address_valid is low, data_valid SHALL be ignored; an address_valid fall SHALL take priority over a coincident byte.
REQ-024 A write already scheduled by REQ-019 SHALL still complete even if address_valid falls in that same cycle.
REQ-025 On the return to IDLE, if the transaction produced at least one write, refresh_pending SHALL be set.
REQ-026 refresh_o SHALL pulse for one cycle when the FSM is in IDLE, refresh_pending is 1 and drv_busy_i is 0; refresh_pending SHALL clear in that same cycle.
REQ-027 Refresh SHALL NOT be issued outside IDLE; a pending refresh SHALL survive a new transaction and fire at its end.
REQ-028 Multiple transactions completing while drv_busy_i is high SHALL coalesce into a single refresh_o pulse.
REQ-029 Nothing in this block SHALL depend on a byte count; frames longer than NUM_LEDS entries SHALL keep wrapping per REQ-020.

Reset
REQ-030 reset SHALL put the FSM in IDLE and clear the index, colour bytes, write count, refresh_pending and the address_valid edge register.
REQ-031 Under reset, wr_en_o, refresh_o and idx_err_o SHALL be 0, wr_addr_o SHALL be 0 and wr_data_o SHALL be 24'h000000.
REQ-032 Reset asserted mid-transaction SHALL suppress any pending write or refresh.
REQ-033 After reset, a new transaction SHALL only be recognised by a fresh address_valid rising edge.

Verification
REQ-034 address_valid rise; bytes 00, AB,36,84, D0,25,5A, 00,77,0D; address_valid fall; drv_busy_i=0 -> writes (0,AB3684), (1,D0255A), (2,00770D), then exactly one refresh_o pulse.
REQ-035 NUM_LEDS=8; index byte 07 followed by 6 colour bytes 11..16 -> writes (7,111213), (0,141516).
REQ-036 Index byte 08 followed by 3 colour bytes -> idx_err_o=1, no wr_en_o, no refresh_o.
REQ-037 Index 02, bytes AA,BB, then address_valid fall -> no write, no refresh; the next transaction starts cleanly in INDEX.
REQ-038 drv_busy_i held high across two complete transactions, then released -> exactly one refresh_o pulse, on the first idle cycle after the release.
REQ-039 reset pulsed during C2 -> all outputs at reset values, no write and no refresh afterward.
